// File: rtl/hmi_arbiter_if.sv
// Bundle between the setup/operational controllers and the HMI arbiter.
// The controllers drive requests, digits and buzzer strobes. The arbiter drives the display bus and the buzzer.
interface hmi_arbiter_if;
    logic        setup_req;
    logic [23:0] setup_digits;
    logic [5:0]  setup_blank;
    logic [1:0]  setup_bip_cmd;
    logic        setup_bip_stb;
    logic        op_req;
    logic [23:0] op_digits;
    logic [5:0]  op_blank;
    logic [1:0]  op_bip_cmd;
    logic        op_bip_stb;
    logic [23:0] disp_digits;
    logic [5:0]  disp_blank;
    logic [1:0]  owner;
    logic        bip;
    logic        bip_busy;

    modport master (
        output setup_req, setup_digits, setup_blank, setup_bip_cmd, setup_bip_stb,
        output op_req, op_digits, op_blank, op_bip_cmd, op_bip_stb,
        input  disp_digits, disp_blank, owner, bip, bip_busy
    );

    modport slave (
        input  setup_req, setup_digits, setup_blank, setup_bip_cmd, setup_bip_stb,
        input  op_req, op_digits, op_blank, op_bip_cmd, op_bip_stb,
        output disp_digits, disp_blank, owner, bip, bip_busy
    );
endinterface

// File: rtl/hmi_arbiter.sv
// Fixed-priority owner arbitration of the display and buzzer between the setup and operational controllers.
// Setup has priority. Every hand-over passes through a blank SWITCH cycle. Buzzer patterns are sequenced on a ms timebase.
module hmi_arbiter #(
    parameter int TICK_DIV   = 50000,
    parameter int BEEP_TICKS = 100,
    parameter int GAP_TICKS  = 100
) (
    input  logic         clk,
    input  logic         rst,
    hmi_arbiter_if.slave hmi
);

    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW  = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam int GW  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int TW  = (BW > GW) ? BW : GW;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] B_LAST = TW'(BEEP_TICKS - 1);
    localparam logic [TW-1:0] G_LAST = TW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {IDLE, SWITCH, GRANT_OP, GRANT_SETUP} own_state_t;
    typedef enum logic [1:0] {B_IDLE, B_ON, B_GAP, B_CONT} bip_state_t;

    // Target encoding matches the owner output: 00 none, 01 op, 10 setup
    own_state_t  r_state, w_state_nxt;
    logic [1:0]  r_target, w_target_nxt;
    bip_state_t  r_bstate, w_bstate_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    logic [1:0]  r_beep, w_beep_nxt;
    logic        r_triple, w_triple_nxt;
    logic [1:0]  r_owner;
    logic [23:0] r_disp_digits;
    logic [5:0]  r_disp_blank;
    logic        w_abort;
    logic        w_stb;
    logic [1:0]  w_cmd;
    logic        w_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_target <= 2'b00;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        case (r_state)
            IDLE: begin
                if (hmi.setup_req) begin
                    w_state_nxt  = SWITCH;
                    w_target_nxt = 2'b10;
                end else if (hmi.op_req) begin
                    w_state_nxt  = SWITCH;
                    w_target_nxt = 2'b01;
                end
            end
            SWITCH: begin
                if (r_target == 2'b10 && hmi.setup_req) begin
                    w_state_nxt = GRANT_SETUP;
                end else if (r_target == 2'b01 && hmi.op_req) begin
                    w_state_nxt = GRANT_OP;
                end else if (hmi.setup_req) begin
                    w_state_nxt  = SWITCH;
                    w_target_nxt = 2'b10;
                end else if (hmi.op_req) begin
                    w_state_nxt  = SWITCH;
                    w_target_nxt = 2'b01;
                end else begin
                    w_state_nxt  = IDLE;
                    w_target_nxt = 2'b00;
                end
            end
            GRANT_OP: begin
                if (hmi.setup_req) begin
                    w_state_nxt  = SWITCH;
                    w_target_nxt = 2'b10;
                end else if (!hmi.op_req) begin
                    w_state_nxt  = SWITCH;
                    w_target_nxt = 2'b00;
                end
            end
            GRANT_SETUP: begin
                if (!hmi.setup_req) begin
                    w_state_nxt  = SWITCH;
                    w_target_nxt = hmi.op_req ? 2'b01 : 2'b00;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_target_nxt = 2'b00;
            end
        endcase
    end

    // A strobe counts only if its source keeps ownership across this edge, so a request drop beats a same-cycle strobe
    always_comb begin
        w_abort = (w_state_nxt == SWITCH);
        w_stb   = 1'b0;
        w_cmd   = 2'b00;
        if (r_state == GRANT_OP && w_state_nxt == GRANT_OP) begin
            w_stb = hmi.op_bip_stb;
            w_cmd = hmi.op_bip_cmd;
        end else if (r_state == GRANT_SETUP && w_state_nxt == GRANT_SETUP) begin
            w_stb = hmi.setup_bip_stb;
            w_cmd = hmi.setup_bip_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner       <= 2'b00;
            r_disp_digits <= 24'h000000;
            r_disp_blank  <= 6'h3F;
        end else begin
            case (r_state)
                GRANT_OP: begin
                    r_owner       <= 2'b01;
                    r_disp_digits <= hmi.op_digits;
                    r_disp_blank  <= hmi.op_blank;
                end
                GRANT_SETUP: begin
                    r_owner       <= 2'b10;
                    r_disp_digits <= hmi.setup_digits;
                    r_disp_blank  <= hmi.setup_blank;
                end
                default: begin
                    r_owner       <= 2'b00;
                    r_disp_digits <= 24'h000000;
                    r_disp_blank  <= 6'h3F;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bstate <= B_IDLE;
            r_presc  <= '0;
            r_tcnt   <= '0;
            r_beep   <= 2'd0;
            r_triple <= 1'b0;
        end else begin
            r_bstate <= w_bstate_nxt;
            r_presc  <= w_presc_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_beep   <= w_beep_nxt;
            r_triple <= w_triple_nxt;
        end
    end

    always_comb begin
        w_bstate_nxt = r_bstate;
        w_presc_nxt  = r_presc;
        w_tcnt_nxt   = r_tcnt;
        w_beep_nxt   = r_beep;
        w_triple_nxt = r_triple;
        w_tick       = (r_presc == P_LAST);
        if (w_abort) begin
            w_bstate_nxt = B_IDLE;
            w_presc_nxt  = '0;
            w_tcnt_nxt   = '0;
            w_beep_nxt   = 2'd0;
            w_triple_nxt = 1'b0;
        end else if (w_stb) begin
            w_presc_nxt  = '0;
            w_tcnt_nxt   = '0;
            w_beep_nxt   = 2'd0;
            w_triple_nxt = (w_cmd == 2'b10);
            case (w_cmd)
                2'b01, 2'b10: w_bstate_nxt = B_ON;
                2'b11:        w_bstate_nxt = B_CONT;
                default:      w_bstate_nxt = B_IDLE;
            endcase
        end else if (r_bstate == B_ON || r_bstate == B_GAP) begin
            w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                if (r_bstate == B_ON && r_tcnt == B_LAST) begin
                    w_tcnt_nxt = '0;
                    if (r_triple && r_beep != 2'd2) begin
                        w_bstate_nxt = B_GAP;
                    end else begin
                        w_bstate_nxt = B_IDLE;
                        w_beep_nxt   = 2'd0;
                        w_triple_nxt = 1'b0;
                    end
                end else if (r_bstate == B_GAP && r_tcnt == G_LAST) begin
                    w_tcnt_nxt   = '0;
                    w_beep_nxt   = r_beep + 2'd1;
                    w_bstate_nxt = B_ON;
                end else begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
        end
    end

    assign hmi.owner       = r_owner;
    assign hmi.disp_digits = r_disp_digits;
    assign hmi.disp_blank  = r_disp_blank;
    assign hmi.bip         = (r_bstate == B_ON) || (r_bstate == B_CONT);
    assign hmi.bip_busy    = (r_bstate != B_IDLE);

endmodule
